// File: rtl/keypad_event_conditioner.sv
// keypad_event_conditioner
// Turns eight raw, bouncy keypad lines into clean one-hot key events for a
// consumer that only polls while idle. Each line is synchronised, debounced on
// a divided sample tick and edge-detected. The lowest held key auto-repeats.
// Events wait in a per-key pending set and are delivered lowest index first
// through a one-entry output slot. That slot holds its event until acknowledged.
//
// Ports
//   i_clk        system clock
//   i_rst        asynchronous, active-high reset
//   i_raw_keys   unsynchronised key lines, 1 = pressed
//   i_key_ack    consumer has taken o_keypad (tie high for single-cycle pulses)
//   o_keypad     one-hot key event, held until acknowledged; 0 = none
//   o_key_valid  |o_keypad
//   o_key_state  debounced key levels
module keypad_event_conditioner #(
    parameter int TICK_DIV      = 1000,
    parameter int STABLE_N      = 4,
    parameter int REPEAT_DELAY  = 250,
    parameter int REPEAT_PERIOD = 60
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_raw_keys,
    input  logic       i_key_ack,
    output logic [7:0] o_keypad,
    output logic       o_key_valid,
    output logic [7:0] o_key_state
);

    localparam int TICK_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int REP_W   = $clog2(REP_MAX + 1);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    // Isolate the lowest set bit of a vector
    function automatic logic [7:0] lowest_onehot(input logic [7:0] v);
        lowest_onehot = v & (~v + 8'd1);
    endfunction

    // Index of the lowest set bit (0 when the vector is empty)
    function automatic logic [2:0] lowest_index(input logic [7:0] v);
        lowest_index = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) begin
                lowest_index = 3'(i);
            end
        end
    endfunction

    logic [7:0]          r_sync1;
    logic [7:0]          r_sync2;
    logic [TICK_W-1:0]   r_tick_cnt;
    logic                w_tick;
    logic [STABLE_N-1:0] r_hist      [8];
    logic [STABLE_N-1:0] w_hist_next [8];
    logic [7:0]          r_key_state;
    logic [7:0]          r_key_state_d;
    logic [7:0]          w_rise;
    logic [2:0]          w_rep_idx;
    logic                w_any_held;
    logic                w_rep_same;
    logic                r_rep_held;
    logic [2:0]          r_rep_idx;
    logic [REP_W-1:0]    r_rep_cnt;
    logic [REP_W-1:0]    w_cnt_inc;
    logic [REP_W-1:0]    w_rep_target;
    logic                r_rep_armed;
    logic                w_rep_hit;
    logic                r_rep_fire;
    logic [2:0]          r_rep_fire_idx;
    logic [7:0]          r_pending;
    logic [7:0]          w_set;
    logic [7:0]          w_clr;
    logic                w_load;
    logic [0:0]          r_state;
    logic [7:0]          r_keypad;
    logic                r_key_valid;

    // Two-flop synchroniser on every key line
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1 <= 8'd0;
            r_sync2 <= 8'd0;
        end else begin
            r_sync1 <= i_raw_keys;
            r_sync2 <= r_sync1;
        end
    end

    // Free-running sample-tick divider
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_tick_cnt <= '0;
        end else if (r_tick_cnt == TICK_LAST) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + TICK_W'(1);
        end
    end

    assign w_tick = (r_tick_cnt == TICK_LAST);

    // Sample history including the sample about to be shifted in
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            w_hist_next[i] = {r_hist[i][STABLE_N-2:0], r_sync2[i]};
        end
    end

    // Debounce: a level changes only when the whole history agrees
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < 8; i++) begin
                r_hist[i] <= '0;
            end
            r_key_state <= 8'd0;
        end else if (w_tick) begin
            for (int i = 0; i < 8; i++) begin
                r_hist[i] <= w_hist_next[i];
                if (&w_hist_next[i]) begin
                    r_key_state[i] <= 1'b1;
                end else if (~|w_hist_next[i]) begin
                    r_key_state[i] <= 1'b0;
                end else begin
                    r_key_state[i] <= r_key_state[i];
                end
            end
        end else begin
            r_key_state <= r_key_state;
        end
    end

    // Previous debounced levels for press-edge detection
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_key_state_d <= 8'd0;
        end else begin
            r_key_state_d <= r_key_state;
        end
    end

    assign w_rise     = r_key_state & ~r_key_state_d;
    assign w_rep_idx  = lowest_index(r_key_state);
    assign w_any_held = |r_key_state;
    // The counter only keeps running while the same lowest key stays held
    assign w_rep_same   = w_any_held & r_rep_held & (w_rep_idx == r_rep_idx);
    assign w_cnt_inc    = r_rep_cnt + REP_W'(1);
    assign w_rep_target = r_rep_armed ? REP_W'(REPEAT_PERIOD) : REP_W'(REPEAT_DELAY);
    assign w_rep_hit    = w_rep_same & w_tick & (w_cnt_inc == w_rep_target) &
                          (REPEAT_DELAY != 0);

    // Auto-repeat counter; the fire is registered so repeats land one cycle
    // after the tick, the same relative timing as a press edge
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rep_held     <= 1'b0;
            r_rep_idx      <= 3'd0;
            r_rep_cnt      <= '0;
            r_rep_armed    <= 1'b0;
            r_rep_fire     <= 1'b0;
            r_rep_fire_idx <= 3'd0;
        end else begin
            r_rep_held     <= w_any_held;
            r_rep_idx      <= w_rep_idx;
            r_rep_fire     <= w_rep_hit;
            r_rep_fire_idx <= w_rep_idx;
            if (!w_rep_same) begin
                r_rep_cnt   <= '0;
                r_rep_armed <= 1'b0;
            end else if (w_tick) begin
                if (w_rep_hit) begin
                    r_rep_cnt   <= '0;
                    r_rep_armed <= 1'b1;
                end else begin
                    r_rep_cnt   <= w_cnt_inc;
                    r_rep_armed <= r_rep_armed;
                end
            end else begin
                r_rep_cnt   <= r_rep_cnt;
                r_rep_armed <= r_rep_armed;
            end
        end
    end

    assign w_set  = w_rise | (r_rep_fire ? (8'd1 << r_rep_fire_idx) : 8'd0);
    assign w_load = (r_state == ST_EMPTY) & (|r_pending);
    assign w_clr  = w_load ? lowest_onehot(r_pending) : 8'd0;

    // Pending events: a new set beats a same-cycle clear so no event is lost
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pending <= 8'd0;
        end else begin
            r_pending <= (r_pending & ~w_clr) | w_set;
        end
    end

    // Output slot: load the lowest pending event, hold it until acknowledged
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= ST_EMPTY;
            r_keypad    <= 8'd0;
            r_key_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_load) begin
                        r_keypad    <= w_clr;
                        r_key_valid <= 1'b1;
                        r_state     <= ST_FULL;
                    end else begin
                        r_keypad    <= 8'd0;
                        r_key_valid <= 1'b0;
                        r_state     <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (i_key_ack) begin
                        r_keypad    <= 8'd0;
                        r_key_valid <= 1'b0;
                        r_state     <= ST_EMPTY;
                    end else begin
                        r_keypad    <= r_keypad;
                        r_key_valid <= r_key_valid;
                        r_state     <= ST_FULL;
                    end
                end
                default: begin
                    r_keypad    <= 8'd0;
                    r_key_valid <= 1'b0;
                    r_state     <= ST_EMPTY;
                end
            endcase
        end
    end

    assign o_keypad    = r_keypad;
    assign o_key_valid = r_key_valid;
    assign o_key_state = r_key_state;

endmodule

// File: tb/tb_keypad_event_conditioner.sv
// Directed self-checking bench for keypad_event_conditioner with a small
// tick divider so debounce and auto-repeat timing can be computed by hand.
module tb_keypad_event_conditioner;

    localparam int TICK_DIV      = 4;
    localparam int STABLE_N      = 3;
    localparam int REPEAT_DELAY  = 5;
    localparam int REPEAT_PERIOD = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] raw_keys;
    logic       key_ack;
    logic [7:0] keypad;
    logic       key_valid;
    logic [7:0] key_state;

    int n_pass   = 0;
    int n_checks = 0;

    always #5 clk = ~clk;

    keypad_event_conditioner #(
        .TICK_DIV      (TICK_DIV),
        .STABLE_N      (STABLE_N),
        .REPEAT_DELAY  (REPEAT_DELAY),
        .REPEAT_PERIOD (REPEAT_PERIOD)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_raw_keys  (raw_keys),
        .i_key_ack   (key_ack),
        .o_keypad    (keypad),
        .o_key_valid (key_valid),
        .o_key_state (key_state)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Wait up to limit negedges for a non-zero keypad; cycles = -1 on timeout
    task automatic wait_event(input int limit, output int cycles);
        cycles = -1;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            if (keypad != 8'd0) begin
                cycles = i;
                break;
            end
        end
    endtask

    // Release everything and acknowledge whatever is still queued
    task automatic drain(input string tag);
        raw_keys = 8'd0;
        key_ack  = 1'b1;
        idle(40);
        key_ack  = 1'b0;
        idle(2);
        check_eq(tag, {24'd0, keypad}, 32'h0);
    endtask

    int         n;
    logic       ok;
    logic       multi;
    logic       wide;
    int         nev;
    logic [7:0] kp;
    logic [7:0] prev;
    logic [7:0] ev_val [4];
    int         ev_cyc [4];

    initial begin
        rst      = 1'b1;
        raw_keys = 8'd0;
        key_ack  = 1'b0;
        idle(3);
        check_eq("reset_keypad", {24'd0, keypad}, 32'h0);
        check_eq("reset_valid", {31'd0, key_valid}, 32'h0);
        check_eq("reset_state", {24'd0, key_state}, 32'h0);
        rst = 1'b0;
        idle(2);

        // 1: single held key, held until acknowledged
        raw_keys = 8'h04;
        wait_event(20, n);
        check_eq("t1_latency_le16", {31'd0, (n >= 1 && n <= 16)}, 32'h1);
        check_eq("t1_keypad", {24'd0, keypad}, 32'h04);
        check_eq("t1_valid", {31'd0, key_valid}, 32'h1);
        ok = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (keypad !== 8'h04) ok = 1'b0;
        end
        check_eq("t1_held_until_ack", {31'd0, ok}, 32'h1);
        check_eq("t1_key_state", {24'd0, key_state}, 32'h04);
        key_ack = 1'b1;
        @(negedge clk);
        check_eq("t1_cleared_keypad", {24'd0, keypad}, 32'h0);
        check_eq("t1_cleared_valid", {31'd0, key_valid}, 32'h0);
        key_ack = 1'b0;
        drain("t1_drain");
        check_eq("t1_released_state", {24'd0, key_state}, 32'h0);
        idle(20);
        check_eq("t1_release_no_event", {24'd0, keypad}, 32'h0);

        // 2: bounce on line 1 faster than the debounce window
        ok = 1'b1;
        for (int c = 0; c < 100; c++) begin
            if (c % 3 == 0) raw_keys[1] = ~raw_keys[1];
            @(negedge clk);
            if (key_state[1] !== 1'b0 || keypad !== 8'h00) ok = 1'b0;
        end
        check_eq("t2_bounce_ignored", {31'd0, ok}, 32'h1);
        raw_keys = 8'd0;
        idle(20);
        check_eq("t2_no_event", {24'd0, keypad}, 32'h0);

        // 3: two keys pressed together, delivered low index first
        raw_keys = 8'h09;
        nev      = 0;
        prev     = 8'd0;
        multi    = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            kp = keypad;
            if ($countones(kp) > 1) multi = 1'b1;
            if (kp != 8'd0 && kp != prev && nev < 2) begin
                ev_val[nev] = kp;
                ev_cyc[nev] = c;
                nev++;
            end
            prev    = kp;
            key_ack = (kp != 8'd0);
            if (nev == 2) break;
        end
        @(negedge clk);
        key_ack  = 1'b0;
        raw_keys = 8'd0;
        check_eq("t3_event_count", nev, 32'd2);
        check_eq("t3_first", {24'd0, ev_val[0]}, 32'h01);
        check_eq("t3_second", {24'd0, ev_val[1]}, 32'h08);
        check_eq("t3_gap", {31'd0, (ev_cyc[1] - ev_cyc[0] >= 2)}, 32'h1);
        check_eq("t3_never_both", {31'd0, multi}, 32'h0);
        drain("t3_drain");

        // 4: auto-repeat with ack tied high
        raw_keys = 8'h02;
        key_ack  = 1'b1;
        nev      = 0;
        prev     = 8'd0;
        wide     = 1'b0;
        ok       = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            kp = keypad;
            if (kp != 8'd0 && prev != 8'd0) wide = 1'b1;
            if (kp != 8'd0 && prev == 8'd0 && nev < 4) begin
                if (kp !== 8'h02) ok = 1'b0;
                ev_cyc[nev] = c;
                nev++;
            end
            prev = kp;
        end
        check_eq("t4_pulse_count", {31'd0, (nev == 4)}, 32'h1);
        check_eq("t4_pulse_value", {31'd0, ok}, 32'h1);
        check_eq("t4_single_cycle", {31'd0, wide}, 32'h0);
        check_eq("t4_first_repeat", ev_cyc[1] - ev_cyc[0], 32'd20);
        check_eq("t4_repeat_2", ev_cyc[2] - ev_cyc[1], 32'd8);
        check_eq("t4_repeat_3", ev_cyc[3] - ev_cyc[2], 32'd8);
        drain("t4_drain");

        // 5: reset while an event is held, key kept pressed across reset
        raw_keys = 8'h02;
        key_ack  = 1'b0;
        wait_event(20, n);
        check_eq("t5_pre_keypad", {24'd0, keypad}, 32'h02);
        rst = 1'b1;
        #1;
        check_eq("t5_rst_keypad", {24'd0, keypad}, 32'h0);
        check_eq("t5_rst_state", {24'd0, key_state}, 32'h0);
        check_eq("t5_rst_valid", {31'd0, key_valid}, 32'h0);
        idle(2);
        rst = 1'b0;
        wait_event(30, n);
        check_eq("t5_redebounce_latency", n, 32'd14);
        check_eq("t5_reemit", {24'd0, keypad}, 32'h02);
        drain("t5_drain");

        // 6: press key 0 while key 2's event is still unacknowledged
        raw_keys = 8'h04;
        wait_event(20, n);
        check_eq("t6_first", {24'd0, keypad}, 32'h04);
        raw_keys = 8'h05;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (key_state[0]) break;
        end
        check_eq("t6_key0_state", {31'd0, key_state[0]}, 32'h1);
        idle(2);
        check_eq("t6_slot_held", {24'd0, keypad}, 32'h04);
        key_ack = 1'b1;
        @(negedge clk);
        check_eq("t6_gap", {24'd0, keypad}, 32'h0);
        key_ack = 1'b0;
        @(negedge clk);
        check_eq("t6_pending_delivered", {24'd0, keypad}, 32'h01);
        drain("t6_drain");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
